ccc_lock_reset_sequencer: RTL

- Sits directly downstream of the fabric CCC.
- Clocked by the CCC global output GL0. Consumes the CCC LOCK output, which is asynchronous to GL0.
- Produces staged, glitch-filtered, synchronously released resets: first the general fabric logic, then the CoreTSE MAC/webserver datapath.
- Counts PLL lock-loss events for debug.

---
 rtl/ccc_rst_pkg.sv | 20 ++
 rtl/ccc_lock_sync.sv | 24 ++
 rtl/ccc_lock_reset_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ccc_rst_pkg.sv
// Shared types and constants for the CCC lock/reset sequencer.
// State encoding is exported on the STATE debug port.
package ccc_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    STABILIZE  = 3'd1,
    REL_FABRIC = 3'd2,
    RUN        = 3'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

  // Counter width for a terminal count of n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
// Chain resets to 0 so the synchronized status reads inactive out of reset.
module ccc_lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_sequencer.sv
// Staged, lock-qualified reset release for fabric and MAC logic
// downstream of the CCC, with filtered lock-loss detection and counting.
module ccc_lock_reset_sequencer
  import ccc_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP_CYCLES = 16,
  parameter int LOCK_FILTER_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  SOFT_RST_REQ,
  output logic                  FABRIC_RESET,
  output logic                  MAC_RESET,
  output logic                  READY,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [2:0]            STATE
);

  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
  localparam int GW = cnt_w(RELEASE_GAP_CYCLES);
  localparam int FW = cnt_w(LOCK_FILTER_CYCLES);

  localparam logic [SW-1:0] STABLE_LAST =
    SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST =
    FW'(LOCK_FILTER_CYCLES - 1);

  logic lock_s;

  state_t state;
  state_t state_n;

  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_n;
  logic [FW-1:0] filt_cnt;
  logic [FW-1:0] filt_n;

  logic loss;
  logic fabric_n;
  logic mac_n;
  logic ready_n;
  logic [LOSS_CNT_W-1:0] loss_cnt_n;

  ccc_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (LOCK),
    .q   (lock_s)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= WAIT_LOCK;
      stable_cnt    <= '0;
      gap_cnt       <= '0;
      filt_cnt      <= '0;
      FABRIC_RESET  <= 1'b1;
      MAC_RESET     <= 1'b1;
      READY         <= 1'b0;
      LOCK_LOSS_CNT <= '0;
    end else begin
      state         <= state_n;
      stable_cnt    <= stable_n;
      gap_cnt       <= gap_n;
      filt_cnt      <= filt_n;
      FABRIC_RESET  <= fabric_n;
      MAC_RESET     <= mac_n;
      READY         <= ready_n;
      LOCK_LOSS_CNT <= loss_cnt_n;
    end
  end

  // Counters default to zero so every state entry starts them clean.
  always_comb begin
    state_n  = state;
    stable_n = '0;
    gap_n    = '0;
    filt_n   = '0;
    loss     = 1'b0;
    unique case (state)
      WAIT_LOCK: begin
        if (lock_s) state_n = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
        end else if (stable_cnt == STABLE_LAST) begin
          state_n = REL_FABRIC;
        end else begin
          stable_n = stable_cnt + 1'b1;
        end
      end
      REL_FABRIC, RUN: begin
        if (!lock_s && filt_cnt == FILT_LAST) begin
          loss    = 1'b1;
          state_n = WAIT_LOCK;
        end else if (SOFT_RST_REQ) begin
          state_n = STABILIZE;
        end else begin
          // Filter spans REL_FABRIC->RUN so a low run is never split.
          filt_n = lock_s ? '0 : filt_cnt + 1'b1;
          if (state == REL_FABRIC) begin
            if (gap_cnt == GAP_LAST) begin
              state_n = RUN;
            end else begin
              gap_n = gap_cnt + 1'b1;
            end
          end
        end
      end
      default: begin
        state_n = WAIT_LOCK;
      end
    endcase
  end

  always_comb begin
    fabric_n   = (state_n == WAIT_LOCK) ||
                 (state_n == STABILIZE);
    mac_n      = (state_n != RUN);
    ready_n    = (state_n == RUN);
    loss_cnt_n = LOCK_LOSS_CNT;
    if (loss && LOCK_LOSS_CNT != LOSS_CNT_MAX) begin
      loss_cnt_n = LOCK_LOSS_CNT + 1'b1;
    end
  end

  assign STATE = state;

endmodule
